// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer initiator block.
//   state_t              : 3-bit FSM encoding (IDLE, ARM, WAIT, RELAX, FINISH,
//                          HOLD, FAULT), also visible on the debug port fsm_state
//   DEF_CNT_W            : default width of period count / periods_left
//   DEF_WD_W             : default width of the watchdog counter
//   DEF_TIMEOUT_CYCLES   : default cycles in WAIT before a timer is declared dead
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int DEF_CNT_W          = 8;
    localparam int DEF_WD_W           = 13;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT   = 3'd2,
        RELAX  = 3'd3,
        FINISH = 3'd4,
        HOLD   = 3'd5,
        FAULT  = 3'd6
    } state_t;

endpackage

// File: rtl/detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// Rising-edge detector: one register plus an AND gate.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous, active-high; clears the history register
//   d     in  level input to watch
//   rise  out combinational, high when d=1 and d was 0 on the previous edge
// -----------------------------------------------------------------------------
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/timer_initiator.sv
// -----------------------------------------------------------------------------
// timer_initiator
// Initiator side of the one-shot timer handshake. Issues start pulses to a
// timer, consumes its completion pulse, chains a programmable number of
// periods and flags a timer that never answers.
//
// Optional feature macro: TIMER_INIT_STATS_EN
//   defined   -> adds spurious_cnt, a saturating count of completion edges
//                seen outside WAIT (cleared by reset only)
//   undefined -> port and counter absent
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high; clears all state
//   req           in   user request level, sampled in IDLE
//   num_periods   in   periods to chain, latched when the request is accepted
//   timer_done    in   timer completion (termino), may stay high several cycles
//   timer_start   out  one-cycle start pulse to the timer
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse when all periods have elapsed
//   error         out  high while in FAULT
//   periods_left  out  remaining periods, live
//   spurious_cnt  out  (TIMER_INIT_STATS_EN only) stray completion edges
//   fsm_state     out  debug view of the FSM state register
//
// User handshake: req is a level. It is accepted only in IDLE; the block
// answers with a single done pulse (or with error on a dead timer) and then
// waits for req to return low before it can accept another request, so a
// req held high never retriggers.
// -----------------------------------------------------------------------------
module timer_initiator
    import timer_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int WD_W           = DEF_WD_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [CNT_W-1:0] num_periods,
    input  logic             timer_done,
    output logic             timer_start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] periods_left,
`ifdef TIMER_INIT_STATS_EN
    output logic [CNT_W-1:0] spurious_cnt,
`endif
    output logic [2:0]       fsm_state
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] watchdog;
    logic            rise;

    detector_flanco u_done_edge (
        .clk   (clk),
        .reset (reset),
        .d     (timer_done),
        .rise  (rise)
    );

    assign fsm_state = state;

    // Next-state logic. A completion edge in WAIT takes priority over the
    // watchdog expiring in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (num_periods == '0) ? FINISH : ARM;
                end
            end
            ARM: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (rise) begin
                    // Decrement lands on zero exactly when one period remains.
                    next_state = (periods_left == CNT_W'(1)) ? FINISH : RELAX;
                end else if (watchdog == WD_LAST) begin
                    next_state = FAULT;
                end
            end
            RELAX: begin
                // The timer cannot be restarted until it drops termino.
                if (!timer_done) begin
                    next_state = ARM;
                end
            end
            FINISH: begin
                next_state = HOLD;
            end
            HOLD, FAULT: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and registered outputs. timer_start and done are taken
    // from the current state, so each appears one cycle after ARM / FINISH is
    // entered; busy and error follow the state being entered, so they are
    // high exactly while the FSM sits outside IDLE / in FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            periods_left <= '0;
            watchdog     <= '0;
            timer_start  <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state       <= next_state;
            timer_start <= (state == ARM);
            done        <= (state == FINISH);
            busy        <= (next_state != IDLE);
            error       <= (next_state == FAULT);

            case (state)
                IDLE: begin
                    if (req && (num_periods != '0)) begin
                        periods_left <= num_periods;
                    end
                end
                ARM: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    // Stops at the last value so it never wraps.
                    if (watchdog != WD_LAST) begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                    if (rise) begin
                        periods_left <= periods_left - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TIMER_INIT_STATS_EN
    // Completion edges that arrive when nobody is waiting for them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spurious_cnt <= '0;
        end else if (rise && (state != WAIT) && (spurious_cnt != '1)) begin
            spurious_cnt <= spurious_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
